// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter that drives an external 4:1 mux select and registers the mux output
// into a one-entry valid/ready stage. Optional packet lock enabled by RR_MUX_ARBITER_LOCK_EN.
module rr_mux_arbiter_4 #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic [3:0]     in_last,
`endif
  output logic [3:0]     in_ready,
  output logic [1:0]     sel,
  input  logic [W-1:0]   mux_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_src
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned IDXW = 2;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [IDXW-1:0]   out_src_q, out_src_d;
  logic [IDXW-1:0]   win_c;
  logic              any_req_c;
  logic              can_load_c;
  logic              xfer_in_c;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic              locked_q, locked_d;
  logic [IDXW-1:0]   lock_src_q, lock_src_d;
`endif

  // State register: output stage, priority pointer and optional lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
`ifdef RR_MUX_ARBITER_LOCK_EN
      locked_q   <= 1'b0;
      lock_src_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
`ifdef RR_MUX_ARBITER_LOCK_EN
      locked_q   <= locked_d;
      lock_src_q <= lock_src_d;
`endif
    end
  end

  // Winner search, grant, select and next-state.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    in_ready   = '0;
    win_c      = ptr_q;
    any_req_c  = |in_valid;
`ifdef RR_MUX_ARBITER_LOCK_EN
    locked_d   = locked_q;
    lock_src_d = lock_src_q;
`endif

    // Descending scan so the lowest rotated offset from ptr wins last.
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (in_valid[ptr_q + IDXW'(k)]) begin
        win_c = ptr_q + IDXW'(k);
      end
    end
`ifdef RR_MUX_ARBITER_LOCK_EN
    if (locked_q) begin
      win_c     = lock_src_q;
      any_req_c = in_valid[lock_src_q];
    end
`endif

    sel = any_req_c ? win_c : ptr_q;
`ifdef RR_MUX_ARBITER_LOCK_EN
    if (locked_q) begin
      sel = lock_src_q;
    end
`endif

    can_load_c = (state_q == ST_EMPTY) || out_ready;
    xfer_in_c  = any_req_c && can_load_c && rst_n;

    if (xfer_in_c) begin
      in_ready[win_c] = 1'b1;
      out_data_d      = mux_y;
      out_src_d       = win_c;
      state_d         = ST_FULL;
      ptr_d           = win_c + IDXW'(1);
`ifdef RR_MUX_ARBITER_LOCK_EN
      locked_d        = !in_last[win_c];
      lock_src_d      = win_c;
`endif
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end

    // Select parks at source 0 while reset is held.
    if (!rst_n) begin
      sel = '0;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Scoreboard bench for rr_mux_arbiter_4: a fairness model predicts grants and pushes expected
// words; an independent monitor pops and compares each accepted output word.
module tb_rr_mux_arbiter_4;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic [W-1:0] mux_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic [3:0]   in_last;
  logic [W-1:0] src_data [4];

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: last granted source has lowest priority next time.
  int   last_grant;
  bit   m_full;
  bit   m_locked;
  int   m_lock_src;
  bit   p_xfer;
  int   p_win;
  bit   p_ready;
  bit   p_last;

  logic [3:0] vmask;
  int         vprob;
  int         rprob;
  int         dbase;
  bit         fixed_data;

  always #5 clk = ~clk;

  // External mux model.
  always_comb mux_y = src_data[sel];

  rr_mux_arbiter_4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
`ifdef RR_MUX_ARBITER_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .sel       (sel),
    .mux_y     (mux_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    if (m_locked) return in_valid[m_lock_src] ? m_lock_src : -1;
    for (int k = 1; k <= 4; k++) begin
      int s;
      s = (last_grant + k) % 4;
      if (in_valid[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_grant = 3;
    m_full     = 0;
    m_locked   = 0;
    m_lock_src = 0;
    p_xfer     = 0;
    exp_q.delete();
  endtask

  // Called on the falling edge: predict this cycle's grant and compare visible outputs.
  task automatic predict_and_check();
    int         w;
    bit         can;
    logic [3:0] exp_ready;
    int         exp_sel;
    exp_t       e;
    w         = model_winner();
    can       = !m_full || out_ready;
    exp_ready = '0;
    p_xfer    = 0;
    if (rst_n && w >= 0 && can) begin
      exp_ready[w] = 1'b1;
      p_xfer       = 1;
      p_win        = w;
      p_last       = in_last[w];
      e.src        = 2'(w);
      e.data       = src_data[w];
      exp_q.push_back(e);
    end
    if (!rst_n)        exp_sel = 0;
    else if (m_locked) exp_sel = m_lock_src;
    else if (w >= 0)   exp_sel = w;
    else               exp_sel = (last_grant + 1) % 4;
    p_ready = out_ready;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("sel", 32'(sel), 32'(exp_sel));
    check("out_valid", 32'(out_valid), 32'(m_full));
  endtask

  task automatic update_model();
    if (p_xfer) begin
      last_grant = p_win;
      m_full     = 1;
`ifdef RR_MUX_ARBITER_LOCK_EN
      m_locked   = !p_last;
      m_lock_src = p_win;
`endif
    end else if (m_full && p_ready) begin
      m_full = 0;
    end
  endtask

  // Sources hold valid and data until accepted; new words appear per vmask/vprob.
  task automatic drive_next();
    logic [3:0] iv;
    iv = in_valid;
    for (int i = 0; i < 4; i++) begin
      if (p_xfer && p_win == i) iv[i] = 1'b0;
      if (!iv[i] && vmask[i] && ($urandom_range(99) < 32'(vprob))) begin
        iv[i]       = 1'b1;
        src_data[i] = fixed_data ? W'(dbase + i) : W'($urandom);
        in_last[i]  = 1'($urandom);
      end
    end
    in_valid  = iv;
    out_ready = ($urandom_range(99) < 32'(rprob));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      predict_and_check();
      @(posedge clk);
      #1;
      update_model();
      drive_next();
    end
  endtask

  // Monitor: every accepted output word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_src", 32'(out_src), 32'(e.src));
        check("out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    bit seen;
    model_reset();
    rst_n      = 1'b0;
    in_valid   = 4'b1111;
    in_last    = 4'b1111;
    out_ready  = 1'b1;
    vmask      = 4'b1111;
    vprob      = 100;
    rprob      = 100;
    dbase      = 1;
    fixed_data = 1;
    for (int i = 0; i < 4; i++) src_data[i] = W'(i + 1);

    // Reset with all sources requesting.
    run(2);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    rst_n = 1'b1;

    // All valid, data 1..4: expect 0,1,2,3,0 back to back.
    run(10);

    // Drain, then alternate between sources 1 and 3.
    vmask = 4'b0000;
    run(8);
    vmask = 4'b1010;
    run(10);
    vmask = 4'b0000;
    run(8);

    // Output stall holding data 5 from source 0.
    vmask = 4'b0001;
    dbase = 5;
    rprob = 0;
    out_ready = 1'b0;
    run(4);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_data", 32'(out_data), 32'd5);
    rprob = 100;
    run(4);

    // Randomised traffic.
    vmask      = 4'b1111;
    fixed_data = 0;
    for (int ph = 0; ph < 8; ph++) begin
      vprob = 20 + $urandom_range(80);
      rprob = 30 + $urandom_range(70);
      vmask = 4'($urandom_range(15)) | 4'b0001;
      run(250);
    end

    // Async reset while the output register is full.
    vmask = 4'b1111;
    vprob = 100;
    rprob = 0;
    seen  = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1;
        break;
      end
      run(1);
    end
    check("full_before_reset", 32'(seen), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    check("async_rst_sel", 32'(sel), 32'd0);
    model_reset();
    in_valid   = 4'b1111;
    in_last    = 4'b1111;
    out_ready  = 1'b1;
    rprob      = 100;
    fixed_data = 1;
    dbase      = 1;
    for (int i = 0; i < 4; i++) src_data[i] = W'(i + 1);
    @(posedge clk);
    #1;
    run(1);
    rst_n = 1'b1;
    run(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Round-robin arbiter and output register sitting directly upstream of the 4:1 mux (mux_4_1) and around it.
- Four valid/ready sources compete. The block drives the mux select, captures the mux output (mux_y) into a one-entry output register, and presents it downstream with valid/ready.
- Converts the purely combinational mux into a fair, flow-controlled 4-to-1 merge stage.

Parameters:
- W, 4, data width of each source, of mux_y and of out_data; matches the mux data width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  4  per-source request; bit i belongs to source i (mux input d<i>)
- in_ready  output  4  per-source accept; at most one bit high
- sel  output  2  select to the external mux; source index
- mux_y  input  W  data returned from the external mux for the current sel
- out_valid  output  1  output register holds data
- out_ready  input  1  downstream accept
- out_data  output  W  registered data
- out_src  output  2  source index of out_data

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_src=0, priority pointer ptr=0. in_ready=0 and sel=ptr=0 while in reset.
- Output register states:
  - EMPTY (out_valid=0); FULL (out_valid=1).
  - can_load = !out_valid || out_ready.
- Winner (combinational):
  - First i with in_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - any_req = |in_valid.
- sel = winner when any_req, else sel = ptr. Combinational, no register stage.
- in_ready[i] = any_req && can_load && (i == winner); all other bits 0.
- Transfer in: in_valid[winner] && in_ready[winner] on a rising edge. Then:
  - out_data <= mux_y, out_src <= winner, out_valid <= 1.
  - ptr <= winner+1 (2-bit wrap, 3 -> 0).
- Transfer out: out_valid && out_ready. If no transfer in happens in the same cycle: out_valid <= 0; out_data and out_src hold their values.
- Simultaneous in and out transfers: register reloads with new data, out_valid stays 1. Throughput is 1 word/cycle.
- Latency: 1 cycle from in_valid[i]=1 (with can_load) to out_valid=1 carrying that data.
- FULL && !out_ready: in_ready=0, out_data/out_src/out_valid stable, ptr unchanged.
- No request: ptr unchanged, no state change apart from the drain rule above.
- Fairness:
  - A source that is continuously valid is granted within 4 transfers.
  - The source just granted has lowest priority next time.
- Sources must hold in_valid and data until accepted; the block does not check this.
- Reset asserted mid-transfer: state clears immediately; any data in flight is dropped. Sources re-present after reset.

Optional Feature:
- Macro RR_MUX_ARBITER_LOCK_EN. With it:
  - Extra input in_last[3:0].
  - After a transfer in from source g with in_last[g]=0, the arbiter locks to g: winner=g regardless of other requests. in_ready goes only to g, and only when in_valid[g]=1.
  - Lock releases after a transfer in from g with in_last[g]=1; ptr then advances to g+1.
  - While locked and in_valid[g]=0, sel=g and no grant is given.
  - Reset clears the lock.
- Without it: no in_last port; arbitration happens on every transfer.

Test Plan:
- Reset: rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, sel=0; release -> first grant to source 0.
- All four sources valid, out_ready=1, mux_y returning d0..d3=1,2,3,4 -> out_src sequence 0,1,2,3,0; out_data sequence 1,2,3,4,1; one word per cycle after 1-cycle latency.
- in_valid=4'b1010, out_ready=1 -> grants alternate 1,3,1,3; sources 0 and 2 are never granted.
- Output stall: FULL with out_data=5, out_ready=0 for 3 cycles, in_valid=4'b0001 -> in_ready=0, out_data stays 5; out_ready=1 -> reload in the same cycle, out_valid stays 1.
- Async reset asserted mid-stream while out_valid=1 -> out_valid drops to 0 before the next clock edge; ptr returns to 0.
- LOCK_EN: source 2 sends 3 words with in_last=0,0,1 while source 0 is valid throughout -> out_src=2,2,2, then 0.
